dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: direct-mapped tag array in front of a 16-bit word array,
// one-cycle hits, fixed-latency misses, write-through/write-allocate, saturating stats.
module dmem_responder #(
    parameter int unsigned MISS_LAT = 4,
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned MEM_AW   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] hit_count,
    output logic [15:0] req_count
);
    localparam int unsigned TAG_W   = 16 - IDX_BITS - 1;
    localparam int unsigned N_ENT   = 1 << IDX_BITS;
    localparam int unsigned N_WORDS = 1 << MEM_AW;
    localparam logic [3:0]  MISS_LOAD = 4'(MISS_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

    state_t              r_state;
    logic [15:0]         r_addr;
    logic [15:0]         r_data;
    logic                r_rd;
    logic                r_wr;
    logic [3:0]          r_cnt;
    logic [N_ENT-1:0]    r_valid;
    logic [15:0]         r_hit_cnt;
    logic [15:0]         r_req_cnt;
    logic [TAG_W-1:0]    r_tags [N_ENT];
    logic [15:0]         r_mem  [N_WORDS];

    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [MEM_AW-1:0]   w_word;
    logic                w_illegal;
    logic                w_hit;
    logic                w_lookup_hit;
    logic                w_lookup_err;
    logic                w_miss_done;
    logic                w_done;
    logic                w_busy;
    logic                w_stall;
    logic                w_accept;
    logic                w_mem_we;

    assign w_idx        = r_addr[IDX_BITS:1];
    assign w_tag        = r_addr[15:IDX_BITS+1];
    assign w_word       = r_addr[MEM_AW:1];
    assign w_illegal    = (r_rd & r_wr) | r_addr[0];
    assign w_hit        = r_valid[w_idx] & (r_tags[w_idx] == w_tag);
    assign w_lookup_hit = (r_state == LOOKUP) & ~w_illegal & w_hit;
    assign w_lookup_err = (r_state == LOOKUP) & w_illegal;
    assign w_miss_done  = (r_state == MISS) & (r_cnt == 4'd0);
    assign w_done       = w_lookup_hit | w_lookup_err | w_miss_done;
    assign w_busy       = (r_state == LOOKUP) | (r_state == MISS);
    assign w_stall      = w_busy & ~w_done;
    assign w_accept     = (Rd | Wr) & ~w_stall;
    // Illegal requests never reach MISS, so only legal writes commit here.
    assign w_mem_we     = r_wr & (w_lookup_hit | w_miss_done);

    assign Done      = w_done;
    assign Stall     = w_stall;
    assign CacheHit  = w_lookup_hit;
    assign err       = w_lookup_err;
    assign DataOut   = (w_done && r_rd && !w_illegal) ? r_mem[w_word] : 16'h0000;
    assign hit_count = r_hit_cnt;
    assign req_count = r_req_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= 16'h0000;
            r_data    <= 16'h0000;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_cnt     <= 4'd0;
            r_valid   <= '0;
            r_hit_cnt <= 16'h0000;
            r_req_cnt <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_addr <= Addr;
                r_data <= DataIn;
                r_rd   <= Rd;
                r_wr   <= Wr;
            end
            if (w_accept && r_req_cnt != 16'hFFFF) begin
                r_req_cnt <= r_req_cnt + 16'd1;
            end
            if (w_lookup_hit && r_hit_cnt != 16'hFFFF) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss_done) begin
                r_valid[w_idx] <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= LOOKUP;
                end
                LOOKUP: begin
                    if (w_done) begin
                        r_state <= w_accept ? LOOKUP : RESP;
                    end else begin
                        r_cnt   <= MISS_LOAD;
                        r_state <= MISS;
                    end
                end
                MISS: begin
                    if (w_done) begin
                        r_state <= w_accept ? LOOKUP : RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= w_accept ? LOOKUP : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Backing store and tags keep their contents across reset; only valid bits clear.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_word] <= r_data;
        end
        if (w_miss_done) begin
            r_tags[w_idx] <= w_tag;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: cold/hit reads, write-read forwarding, eviction,
// illegal requests, reset during a miss and counter saturation.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] hit_count;
    logic [15:0] req_count;

    int n_tests;
    int n_fail;

    dmem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rd        (Rd),
        .Wr        (Wr),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .hit_count (hit_count),
        .req_count (req_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one request and collects the response cycle; lat=0 means no Done seen.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output int nstall,
                          output logic [15:0] dout, output logic hit, output logic er,
                          output logic st, output logic leak);
        bit seen;
        lat = 0; nstall = 0; dout = 16'hxxxx; hit = 1'bx; er = 1'bx; st = 1'bx;
        leak = 1'b0; seen = 0;
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(posedge clk);
        #1 Rd = 1'b0; Wr = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (Done) begin
                lat = c; dout = DataOut; hit = CacheHit; er = err; st = Stall; seen = 1;
            end else begin
                if (Stall) nstall++;
                if (DataOut != 16'h0 || CacheHit || err) leak = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0;
        repeat (3) @(negedge clk);
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Stall); end
        n_tests++; if (CacheHit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", CacheHit); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_tests++; if (DataOut !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", DataOut); end
        n_tests++; if (hit_count !== 16'h0) begin n_fail++; $display("FAIL reset_hitcnt got %h want 0000", hit_count); end
        n_tests++; if (req_count !== 16'h0) begin n_fail++; $display("FAIL reset_reqcnt got %h want 0000 (Rd ignored in reset)", req_count); end
        Rd = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_cold_read;
        int lat, ns; logic [15:0] d; logic h, e, s, lk;
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL cold_lat got %0d want 5", lat); end
        n_tests++; if (ns != 4) begin n_fail++; $display("FAIL cold_stall_cycles got %0d want 4", ns); end
        n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL cold_hit got %b want 0", h); end
        n_tests++; if (s !== 1'b0) begin n_fail++; $display("FAIL cold_stall_at_done got %b want 0", s); end
        n_tests++; if (lk !== 1'b0) begin n_fail++; $display("FAIL cold_idle_outputs got %b want 0", lk); end
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL warm_lat got %0d want 1", lat); end
        n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL warm_hit got %b want 1", h); end
        @(negedge clk);
        n_tests++; if (hit_count !== 16'd1) begin n_fail++; $display("FAIL warm_hitcnt got %0d want 1", hit_count); end
        n_tests++; if (req_count !== 16'd2) begin n_fail++; $display("FAIL warm_reqcnt got %0d want 2", req_count); end
    endtask

    task automatic test_back_to_back;
        int lat, ns; logic [15:0] d; logic h, e, s, lk;
        bit seen;
        seen = 0; lat = 0;
        @(negedge clk);
        Wr = 1'b1; Rd = 1'b0; Addr = 16'h0020; DataIn = 16'hBEEF;
        @(posedge clk);
        #1 Wr = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (Done) begin lat = c; seen = 1; end
        end
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL wr_miss_lat got %0d want 5", lat); end
        n_tests++; if (CacheHit !== 1'b0) begin n_fail++; $display("FAIL wr_miss_hit got %b want 0", CacheHit); end
        Rd = 1'b1; Addr = 16'h0020;
        @(posedge clk);
        #1 Rd = 1'b0;
        @(negedge clk);
        n_tests++; if (Done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", Done); end
        n_tests++; if (CacheHit !== 1'b1) begin n_fail++; $display("FAIL b2b_hit got %b want 1", CacheHit); end
        n_tests++; if (DataOut !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data got %h want beef", DataOut); end
        do_req(1'b0, 1'b1, 16'h0020, 16'hCAFE, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 1 || h !== 1'b1) begin n_fail++; $display("FAIL wr_hit got lat %0d hit %b want 1 1", lat, h); end
        do_req(1'b1, 1'b0, 16'h0020, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (d !== 16'hCAFE) begin n_fail++; $display("FAIL wr_hit_data got %h want cafe", d); end
    endtask

    task automatic test_conflict;
        int lat, ns; logic [15:0] d; logic h, e, s, lk;
        do_req(1'b1, 1'b0, 16'h0002, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5 || h !== 1'b0) begin n_fail++; $display("FAIL conf_a got lat %0d hit %b want 5 0", lat, h); end
        do_req(1'b1, 1'b0, 16'h0022, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5 || h !== 1'b0) begin n_fail++; $display("FAIL conf_b got lat %0d hit %b want 5 0", lat, h); end
        do_req(1'b1, 1'b0, 16'h0002, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5 || h !== 1'b0) begin n_fail++; $display("FAIL conf_evict got lat %0d hit %b want 5 0", lat, h); end
    endtask

    task automatic test_illegal;
        int lat, ns; logic [15:0] d; logic h, e, s, lk;
        // 0x0804 aliases word 2 in memory but carries a different tag than 0x0004.
        do_req(1'b0, 1'b1, 16'h0804, 16'h1111, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL alias_wr_lat got %0d want 5", lat); end
        do_req(1'b1, 1'b1, 16'h0004, 16'hDEAD, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL ill_rw_lat got %0d want 1", lat); end
        n_tests++; if (e !== 1'b1 || h !== 1'b0) begin n_fail++; $display("FAIL ill_rw_flags got err %b hit %b want 1 0", e, h); end
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL ill_rw_data got %h want 0000", d); end
        do_req(1'b1, 1'b0, 16'h0005, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 1 || e !== 1'b1) begin n_fail++; $display("FAIL ill_odd got lat %0d err %b want 1 1", lat, e); end
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL ill_odd_data got %h want 0000", d); end
        do_req(1'b1, 1'b0, 16'h0004, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5 || h !== 1'b0 || e !== 1'b0) begin n_fail++; $display("FAIL ill_follow got lat %0d hit %b err %b want 5 0 0", lat, h, e); end
        n_tests++; if (d !== 16'h1111) begin n_fail++; $display("FAIL ill_follow_data got %h want 1111", d); end
    endtask

    task automatic test_reset_mid_miss;
        int lat, ns; logic [15:0] d; logic h, e, s, lk;
        logic done_seen;
        done_seen = 1'b0;
        do_req(1'b0, 1'b1, 16'h0840, 16'h5555, lat, ns, d, h, e, s, lk);
        @(negedge clk);
        Wr = 1'b1; Rd = 1'b0; Addr = 16'h0040; DataIn = 16'h1234;
        @(posedge clk);
        #1 Wr = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL mid_miss_stall got %b want 1", Stall); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (Stall !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_clear got stall %b done %b want 0 0", Stall, Done); end
        n_tests++; if (req_count !== 16'h0 || hit_count !== 16'h0) begin n_fail++; $display("FAIL mid_rst_cnt got %h %h want 0 0", req_count, hit_count); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (Done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (Done) done_seen = 1'b1;
        end
        n_tests++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_done got %b want 0", done_seen); end
        do_req(1'b1, 1'b0, 16'h0040, 16'h0, lat, ns, d, h, e, s, lk);
        n_tests++; if (lat != 5 || h !== 1'b0) begin n_fail++; $display("FAIL post_rst_miss got lat %0d hit %b want 5 0", lat, h); end
        n_tests++; if (d !== 16'h5555) begin n_fail++; $display("FAIL post_rst_data got %h want 5555", d); end
    endtask

    task automatic test_saturation;
        int hits;
        hits = 0;
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0040;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (Done && CacheHit) hits++;
        end
        Rd = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (hits != 65540) begin n_fail++; $display("FAIL sat_hits got %0d want 65540", hits); end
        n_tests++; if (hit_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hitcnt got %h want ffff", hit_count); end
        n_tests++; if (req_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reqcnt got %h want ffff", req_count); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        test_reset;
        test_cold_read;
        test_back_to_back;
        test_conflict;
        test_illegal;
        test_reset_mid_miss;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
